// File: rtl/voltage_fmt_pkg.sv
`default_nettype none
// ============================================================================
//  Module : voltage_fmt_pkg
//  Brief  : Shared definitions for the voltage ASCII formatter: FSM state
//           encoding, ASCII byte constants, default full-scale value and the
//           double-dabble step helper used by the BCD converter.
//  Ports  : (package, no ports)
//  Rev    : 1.0  initial release
// ============================================================================
package voltage_fmt_pkg;

  // Default saturation limit in 0.1 mV units (5.0000 V).
  localparam int unsigned FULL_SCALE_DEFAULT = 50000;

  // Control FSM encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  // ASCII bytes used in the output frame.
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_V     = 8'h56;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  // One double-dabble iteration on {bcd[19:0], bin[15:0]}: every BCD digit
  // that is 5 or more gets +3 so that the following left shift carries
  // correctly into the next decimal digit.
  function automatic logic [35:0] dd_step(input logic [35:0] sr);
    logic [35:0] t;
    t = sr;
    for (int d = 0; d < 5; d++) begin
      if (t[16+4*d +: 4] >= 4'd5) begin
        t[16+4*d +: 4] = t[16+4*d +: 4] + 4'd3;
      end
    end
    return {t[34:0], 1'b0};
  endfunction

  // BCD digit to its ASCII character.
  function automatic logic [7:0] digit_ascii(input logic [3:0] d);
    return ASCII_ZERO | {4'b0000, d};
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module : bin2bcd_seq
//  Brief  : Sequential 16-bit binary to 5-digit BCD converter, one
//           shift-add-3 step per clock, 16 steps per conversion.
//  Ports  : clk   - clock (rising edge)
//           rst   - asynchronous reset, active-high
//           start - load bin and begin a conversion
//           bin   - binary value to convert
//           done  - one-cycle pulse, bcd valid in this cycle
//           bcd   - five BCD digits, most significant in [19:16]
//  Rev    : 1.0  initial release
// ============================================================================
module bin2bcd_seq
  import voltage_fmt_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        done,
  output logic [19:0] bcd
);

  logic [35:0] sr;       // {bcd digits, remaining binary bits}
  logic [4:0]  cnt;      // steps still to perform
  logic        done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr     <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        sr  <= {20'd0, bin};
        cnt <= 5'd16;
      end else if (cnt != 5'd0) begin
        sr  <= dd_step(sr);
        cnt <= cnt - 5'd1;
        // The step that empties the counter is the final one.
        if (cnt == 5'd1) begin
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done = done_q;
  assign bcd  = sr[35:16];

endmodule
`default_nettype wire

// File: rtl/voltage_ascii_fmt.sv
`default_nettype none
// ============================================================================
//  Module : voltage_ascii_fmt
//  Brief  : Converts a signed voltage sample (magnitude in 0.1 mV units plus
//           an ASCII sign byte) into an ASCII frame "sD.DDDDV[CR LF]" and
//           streams it byte by byte over a valid/ready interface.
//  Ports  : clk, rst        - clock, asynchronous active-high reset
//           hex, sign       - sample magnitude / ASCII sign ('+' or '-')
//           in_valid        - sample qualifier
//           in_ready        - high when a sample can be accepted
//           tx_data,tx_valid,tx_ready - byte stream to the transmitter
//           bcd, bcd_valid  - converted digits and their update pulse
//           ovr             - last accepted sample was saturated
//           busy            - block is converting or sending
//  Rev    : 1.0  initial release
// ============================================================================
module voltage_ascii_fmt
  import voltage_fmt_pkg::*;
#(
  parameter int unsigned FULL_SCALE  = FULL_SCALE_DEFAULT,
  parameter bit          APPEND_CRLF = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] hex,
  input  logic [7:0]  sign,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [19:0] bcd,
  output logic        bcd_valid,
  output logic        ovr,
  output logic        busy
);

  localparam logic [15:0] FS16     = FULL_SCALE[15:0];
  localparam logic [3:0]  LAST_IDX = APPEND_CRLF ? 4'd9 : 4'd7;

  logic [1:0]  state;
  logic [3:0]  idx;
  logic [15:0] val;
  logic        neg;
  logic        ovr_q;
  logic [19:0] bcd_q;
  logic        bcd_valid_q;
  logic        armed;       // keeps in_ready low until the first edge after reset

  logic        accept;
  logic        over;
  logic [15:0] sat;
  logic        conv_done;
  logic [19:0] conv_bcd;
  logic [7:0]  byte_sel;

  assign in_ready = (state == ST_IDLE) && armed;
  assign accept   = in_valid && in_ready;
  assign over     = (hex > FS16);
  assign sat      = over ? FS16 : hex;

  // The converter is loaded on the accept edge directly from the saturated
  // input so that its 16 steps run on the 16 edges that follow.
  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (accept),
    .bin   (sat),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      val         <= '0;
      neg         <= 1'b0;
      ovr_q       <= 1'b0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
      armed       <= 1'b0;
    end else begin
      armed       <= 1'b1;
      bcd_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            val   <= sat;
            ovr_q <= over;
            neg   <= (sign == ASCII_MINUS);
            state <= ST_CONV;
          end
        end
        ST_CONV: begin
          if (conv_done) begin
            bcd_q       <= conv_bcd;
            bcd_valid_q <= 1'b1;
            idx         <= 4'd0;
            state       <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tx_ready) begin
            if (idx == LAST_IDX) begin
              idx   <= 4'd0;
              state <= ST_IDLE;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Byte multiplexer over the frame layout.
  always_comb begin
    byte_sel = 8'h00;
    case (idx)
      4'd0: byte_sel = (neg && (val != 16'd0)) ? ASCII_MINUS : ASCII_PLUS;
      4'd1: byte_sel = digit_ascii(bcd_q[19:16]);
      4'd2: byte_sel = ASCII_DOT;
      4'd3: byte_sel = digit_ascii(bcd_q[15:12]);
      4'd4: byte_sel = digit_ascii(bcd_q[11:8]);
      4'd5: byte_sel = digit_ascii(bcd_q[7:4]);
      4'd6: byte_sel = digit_ascii(bcd_q[3:0]);
      4'd7: byte_sel = ASCII_V;
      4'd8: byte_sel = ASCII_CR;
      4'd9: byte_sel = ASCII_LF;
      default: byte_sel = 8'h00;
    endcase
  end

  assign tx_valid  = (state == ST_SEND);
  assign tx_data   = tx_valid ? byte_sel : 8'h00;
  assign bcd       = bcd_q;
  assign bcd_valid = bcd_valid_q;
  assign ovr       = ovr_q;
  assign busy      = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/voltage_ascii_fmt.md
VOLTAGE_ASCII_FMT -- requirements
Module: voltage_ascii_fmt

Interface
REQ-001 Parameter FULL_SCALE, default 50000, maximum magnitude in 0.1 mV units; larger inputs are saturated to it.
REQ-002 Parameter APPEND_CRLF, default 1, meaning 1 = frame ends with CR, LF (10 bytes) and 0 = frame ends after 'V' (8 bytes).
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  asynchronous reset, active-high.
REQ-005 hex  input  16  unsigned magnitude in 0.1 mV units (0..FULL_SCALE nominal).
REQ-006 sign  input  8  ASCII sign byte, '+' (0x2B) or '-' (0x2D).
REQ-007 in_valid  input  1  hex/sign qualify a sample.
REQ-008 in_ready  output  1  block can accept a sample.
REQ-009 tx_data  output  8  ASCII byte to the serial transmitter.
REQ-010 tx_valid  output  1  tx_data is valid.
REQ-011 tx_ready  input  1  transmitter accepts tx_data this cycle.
REQ-012 bcd  output  20  five BCD digits of the latched value, digit 4 in [19:16].
REQ-013 bcd_valid  output  1  one-cycle pulse when bcd is updated.
REQ-014 ovr  output  1  last accepted sample was saturated; held until the next accept.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The block SHALL implement states IDLE, CONV and SEND.
REQ-017 in_ready SHALL be high only in IDLE; a sample is accepted on an edge where in_valid and in_ready are both high, and in_valid is ignored in all other states.
REQ-018 On accept, the block SHALL latch min(hex, FULL_SCALE), set ovr when hex > FULL_SCALE, latch sign, and enter CONV.
REQ-019 CONV SHALL perform one shift-add-3 (double-dabble) step per cycle for exactly 16 cycles, then enter SEND.
REQ-020 On entering SEND, the block SHALL update bcd, pulse bcd_valid for one cycle, and assert tx_valid with byte 0 in the same cycle, i.e. 17 cycles after the accept edge.
REQ-021 The frame SHALL be: sign, d4, '.', d3, d2, d1, d0, 'V', then 0x0D, 0x0A when APPEND_CRLF=1; digits are sent as 0x30+digit.
REQ-022 The sign byte SHALL be '-' only when the latched sign is '-' and the value is nonzero; otherwise it SHALL be '+'.
REQ-023 The byte index SHALL advance only on tx_valid && tx_ready; tx_data SHALL stay stable while tx_valid && !tx_ready.
REQ-024 After the last byte is accepted, the block SHALL return to IDLE with tx_valid low in the next cycle and in_ready high.
REQ-025 tx_ready held low indefinitely SHALL stall SEND without data loss or timeout.
REQ-026 A sample presented in the same cycle as the final byte handshake SHALL NOT be accepted; it is accepted no earlier than the following cycle.

Reset
REQ-027 Asserting rst at any time, including mid-CONV or mid-SEND, SHALL immediately force IDLE and abort the frame with no resumption.
REQ-028 While rst is asserted, in_ready=0 and tx_data, tx_valid, bcd, bcd_valid, ovr and busy SHALL all be 0.
REQ-029 in_ready SHALL become 1 on the first clock edge after rst deasserts.

Structure
REQ-030 Shared package voltage_fmt_pkg SHALL hold the state encoding, ASCII constants ('+', '-', '.', 'V', '0', CR, LF) and the default FULL_SCALE.
REQ-031 The double-dabble datapath SHALL be a sub-module bin2bcd_seq, with ports start, bin[15:0], done and bcd[19:0].
REQ-032 The top level SHALL contain the control FSM, byte index counter and byte multiplexer.

Verification
REQ-033 hex=12345, sign='+', tx_ready=1 -> bcd=0x12345, bytes "+1.2345V\r\n", bcd_valid 17 cycles after accept.
REQ-034 hex=50000, sign='-' -> "-5.0000V\r\n", ovr=0; then hex=60000, sign='+' -> "+5.0000V\r\n", ovr=1.
REQ-035 hex=0, sign='-' -> "+0.0000V\r\n"; APPEND_CRLF=0 build -> frame is exactly 8 bytes.
REQ-036 tx_ready low for 5 cycles while byte 3 ('2' of 12345) is presented -> tx_data holds 0x32 throughout, and no byte is skipped or duplicated.
REQ-037 rst pulsed during byte 5 of SEND -> tx_valid low immediately; the next sample 100 produces a complete "+0.0100V\r\n" frame.
REQ-038 in_valid held high continuously -> only one accept per frame, and no accept during CONV or SEND.
